// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and constants for the elevator call scheduler.
package elev_pkg;

    localparam int DEFAULT_FLOOR_W = 2;

    localparam int GROUND = 0;
    localparam int FIRST  = 1;
    localparam int SECOND = 2;

    typedef enum logic [2:0] {
        IDLE,
        TRAVEL,
        STEP,
        CHECK,
        DOOR
    } sched_state_t;

endpackage

// File: rtl/elev_call_sync.sv
// Per-bit 2-flop synchronizer plus rising-edge detect for call buttons.
// Only built when ELEV_SCHED_SYNC_EN is defined; adds 2 cycles of call latency.
`ifdef ELEV_SCHED_SYNC_EN
module elev_call_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] call_req,
    output logic [WIDTH-1:0] call_rise
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            sync_d_q <= '0;
        end else begin
            meta_q   <= call_req;
            sync_q   <= meta_q;
            sync_d_q <= sync_q;
        end
    end

    assign call_rise = sync_q & ~sync_d_q;

endmodule
`endif

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches calls, paces step pulses, holds door dwell. All outputs registered.
// ELEV_SCHED_SYNC_EN: synchronize and edge-detect call buttons (call latency 1 -> 3 cycles).
module elevator_call_scheduler
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS   = 3,
    parameter int FLOOR_W      = DEFAULT_FLOOR_W,
    parameter int MOVE_GAP     = 4,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    floor_in,
    output logic                  up_request,
    output logic                  down_request,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] calls_pending
);

    localparam int CNT_MAX = (MOVE_GAP > DWELL_CYCLES) ? MOVE_GAP : DWELL_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'(MOVE_GAP - 1);
    localparam logic [CNT_W-1:0]   DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIM  = (FLOOR_W + 1)'(NUM_FLOORS);

    sched_state_t          state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  dir_nxt;
    logic [NUM_FLOORS-1:0] call_set;
    logic [NUM_FLOORS-1:0] here_mask, below_mask, above_mask;
    logic [NUM_FLOORS-1:0] clr_mask, absorb_mask;
    logic                  floor_valid, pend_here, ahead, behind, absorb;

`ifdef ELEV_SCHED_SYNC_EN
    elev_call_sync #(
        .WIDTH (NUM_FLOORS)
    ) u_call_sync (
        .clk       (clk),
        .reset     (reset),
        .call_req  (call_req),
        .call_rise (call_set)
    );
`else
    assign call_set = call_req;
`endif

    assign floor_valid = ({1'b0, floor_in} < FLOOR_LIM);

    // An invalid floor yields empty masks, so nothing is "here", ahead or behind.
    always_comb begin
        here_mask  = '0;
        below_mask = '0;
        above_mask = '0;
        if (floor_valid) begin
            here_mask  = NUM_FLOORS'(1) << floor_in;
            below_mask = here_mask - NUM_FLOORS'(1);
            above_mask = ~(below_mask | here_mask);
        end
    end

    assign pend_here = |(calls_pending & here_mask);
    assign ahead     = dir_up ? |(calls_pending & above_mask) : |(calls_pending & below_mask);
    assign behind    = dir_up ? |(calls_pending & below_mask) : |(calls_pending & above_mask);
    assign absorb    = (state == DOOR) && |(call_set & here_mask);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_up;
        case (state)
            IDLE: begin
                if (floor_valid) begin
                    if (pend_here) begin
                        state_nxt = DOOR;
                        cnt_nxt   = DWELL_LOAD;
                    end else if (ahead) begin
                        state_nxt = TRAVEL;
                        cnt_nxt   = GAP_LOAD;
                    end else if (behind) begin
                        dir_nxt   = ~dir_up;
                        state_nxt = TRAVEL;
                        cnt_nxt   = GAP_LOAD;
                    end
                end
            end
            TRAVEL: begin
                if (!floor_valid) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = STEP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STEP: begin
                state_nxt = floor_valid ? CHECK : IDLE;
            end
            CHECK: begin
                if (!floor_valid) begin
                    state_nxt = IDLE;
                end else if (pend_here) begin
                    state_nxt = DOOR;
                    cnt_nxt   = DWELL_LOAD;
                end else if (ahead) begin
                    state_nxt = TRAVEL;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DOOR: begin
                // A press for the open floor keeps the door open instead of re-queuing.
                if (absorb) begin
                    cnt_nxt = DWELL_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_mask    = ((state_nxt == DOOR) && (state != DOOR)) ? here_mask : '0;
    assign absorb_mask = (state == DOOR) ? here_mask : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            dir_up        <= 1'b1;
            calls_pending <= '0;
            up_request    <= 1'b0;
            down_request  <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            dir_up        <= dir_nxt;
            calls_pending <= (calls_pending & ~clr_mask) | (call_set & ~absorb_mask);
            up_request    <= (state_nxt == STEP) && dir_nxt;
            down_request  <= (state_nxt == STEP) && !dir_nxt;
            door_open     <= (state_nxt == DOOR);
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler with a behavioural floor controller downstream.
module tb_elevator_call_scheduler;
    import elev_pkg::*;

    localparam int NF    = 3;
    localparam int FW    = 2;
    localparam int GAP   = 2;
    localparam int DWELL = 4;
`ifdef ELEV_SCHED_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int DLY = LAT - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call_req;
    logic [FW-1:0] floor_in;
    logic          up_request, down_request, door_open, dir_up;
    logic [NF-1:0] calls_pending;
    logic [FW-1:0] floor_model;
    logic          fault;
    logic [6:0]    obs, exp_v;
    int            checks = 0;
    int            errors = 0;

    elevator_call_scheduler #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .MOVE_GAP     (GAP),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_req      (call_req),
        .floor_in      (floor_in),
        .up_request    (up_request),
        .down_request  (down_request),
        .door_open     (door_open),
        .dir_up        (dir_up),
        .calls_pending (calls_pending)
    );

    always #5 clk = ~clk;

    // Floor controller: moves one floor on the edge that ends a step pulse.
    always @(posedge clk or posedge reset) begin
        if (reset)
            floor_model <= 2'(GROUND);
        else if (up_request && floor_model != 2'(SECOND))
            floor_model <= floor_model + 2'd1;
        else if (down_request && floor_model != 2'(GROUND))
            floor_model <= floor_model - 2'd1;
    end

    assign floor_in = fault ? 2'd3 : floor_model;
    assign obs      = {up_request, down_request, door_open, dir_up, calls_pending};

    task automatic test_reset();
        reset = 1'b1; call_req = '0; fault = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 7'b0001000) begin errors++; $display("FAIL reset_held got %b want %b", obs, 7'b0001000); end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0001000 || dut.state !== IDLE) begin
            errors++; $display("FAIL reset_release got %b state %0d want %b IDLE", obs, dut.state, 7'b0001000);
        end
    endtask

    task automatic test_basic_up();
        for (int k = -DLY; k <= 15; k++) begin
            @(posedge clk); #1;
            call_req = (k == -DLY) ? 3'b100 : 3'b000;
            @(negedge clk);
            exp_v = {(k == 4 || k == 8), 1'b0, (k >= 10 && k <= 13), 1'b1,
                     (k >= 1 && k <= 9) ? 3'b100 : 3'b000};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL basic_up cyc %0d got %b want %b", k, obs, exp_v); end
            if (k == 9) begin
                checks++;
                if (floor_in !== 2'd2) begin errors++; $display("FAIL basic_up_floor got %0d want 2", floor_in); end
            end
            if (k == 14) begin
                checks++;
                if (dut.state !== IDLE) begin errors++; $display("FAIL basic_up_idle got %0d want IDLE", dut.state); end
            end
        end
    endtask

    task automatic test_reverse();
        for (int k = -DLY; k <= 15; k++) begin
            @(posedge clk); #1;
            call_req = (k == -DLY) ? 3'b001 : 3'b000;
            @(negedge clk);
            exp_v = {1'b0, (k == 4 || k == 8), (k >= 10 && k <= 13), (k <= 1),
                     (k >= 1 && k <= 9) ? 3'b001 : 3'b000};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reverse cyc %0d got %b want %b", k, obs, exp_v); end
            if (k == 9) begin
                checks++;
                if (floor_in !== 2'd0) begin errors++; $display("FAIL reverse_floor got %0d want 0", floor_in); end
            end
        end
    endtask

    task automatic test_scan_order();
        logic [2:0] pend_e;
        for (int k = -DLY; k <= 33; k++) begin
            @(posedge clk); #1;
            call_req = (k == -DLY) ? 3'b010 : (k == 3 - DLY) ? 3'b101 : 3'b000;
            @(negedge clk);
            if (k >= 1 && k <= 3)       pend_e = 3'b010;
            else if (k >= 4 && k <= 5)  pend_e = 3'b111;
            else if (k >= 6 && k <= 14) pend_e = 3'b101;
            else if (k >= 15 && k <= 27) pend_e = 3'b001;
            else                        pend_e = 3'b000;
            exp_v = {(k == 4 || k == 13), (k == 22 || k == 26),
                     (k >= 6 && k <= 9) || (k >= 15 && k <= 18) || (k >= 28 && k <= 31),
                     (k >= 2 && k <= 19), pend_e};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL scan_order cyc %0d got %b want %b", k, obs, exp_v); end
        end
    endtask

    task automatic test_door_absorb();
        for (int k = -DLY; k <= 10; k++) begin
            @(posedge clk); #1;
            call_req = (k == -DLY || k == 4 - DLY) ? 3'b001 : 3'b000;
            @(negedge clk);
            exp_v = {1'b0, 1'b0, (k >= 2 && k <= 8), 1'b0, (k == 1) ? 3'b001 : 3'b000};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL door_absorb cyc %0d got %b want %b", k, obs, exp_v); end
            if (k == 9) begin
                checks++;
                if (dut.state !== IDLE) begin errors++; $display("FAIL door_absorb_idle got %0d want IDLE", dut.state); end
            end
        end
    endtask

    task automatic test_reset_in_step();
        for (int k = -DLY; k <= 4; k++) begin
            @(posedge clk); #1;
            call_req = (k == -DLY) ? 3'b100 : 3'b000;
            @(negedge clk);
            exp_v = {(k == 4), 1'b0, 1'b0, (k >= 2), (k >= 1) ? 3'b100 : 3'b000};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL pre_reset cyc %0d got %b want %b", k, obs, exp_v); end
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 7'b0001000 || dut.state !== IDLE) begin
            errors++; $display("FAIL reset_in_step got %b state %0d want %b IDLE", obs, dut.state, 7'b0001000);
        end
        @(posedge clk); #1; reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 7'b0001000 || floor_in !== 2'd0) begin
            errors++; $display("FAIL after_reset got %b floor %0d want %b floor 0", obs, floor_in, 7'b0001000);
        end
    endtask

    task automatic test_fault();
        for (int k = -DLY; k <= 18; k++) begin
            @(posedge clk); #1;
            call_req = (k == -DLY) ? 3'b010 : 3'b000;
            if (k == 2) fault = 1'b1;
            if (k == 8) fault = 1'b0;
            @(negedge clk);
            exp_v = {(k == 11), 1'b0, (k >= 13 && k <= 16), 1'b1,
                     (k >= 1 && k <= 12) ? 3'b010 : 3'b000};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL fault cyc %0d got %b want %b", k, obs, exp_v); end
            if (k >= 3 && k <= 7) begin
                checks++;
                if (dut.state !== IDLE) begin errors++; $display("FAIL fault_idle cyc %0d got %0d want IDLE", k, dut.state); end
            end
            if (k == 12) begin
                checks++;
                if (floor_in !== 2'd1) begin errors++; $display("FAIL fault_floor got %0d want 1", floor_in); end
            end
        end
    endtask

    task automatic test_call_latency();
        int lat;
        lat = 0;
        @(posedge clk); #1;
        call_req = 3'b100;
        while (lat < 10) begin
            @(posedge clk); #1;
            call_req = 3'b000;
            lat++;
            @(negedge clk);
            if (calls_pending[2]) break;
        end
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL call_latency got %0d want %0d", lat, LAT); end
    endtask

    initial begin
        test_reset();
        test_basic_up();
        test_reverse();
        test_scan_order();
        test_door_absorb();
        test_reset_in_step();
        test_fault();
        test_call_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
